seq_div32: RTL and testbench

SEQ_DIV32 -- requirements
Module: seq_div32

---
 rtl/seq_div32.sv | 198 +++++++++++++++++++
 tb/tb_seq_div32.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div32.sv
// Sequential 32-bit restoring divider (quotient, remainder, divide-by-zero flag).
// Latency: done pulses 33 cycles after an accepted start (1 cycle for a zero divisor).
// Backpressure: start is only honoured while busy is low; requests made while busy are dropped.
// Optional signed mode is compiled in with the macro SEQ_DIV32_SIGNED_EN.

module seq_div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotO,
    output logic [WIDTH-1:0] remO,
    output logic             divZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Working registers: quot starts as the dividend magnitude and is shifted
    // out MSB-first while quotient bits are shifted in at the LSB.
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic [CW-1:0]    cnt;
    logic             dz_pend;

    // Operand conditioning and result fix-up (identity in the unsigned build)
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             neg_q_in;
    logic             neg_r_in;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    // One restoring step
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] sub_full;
    logic             borrow;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quot_step;
    logic             unused_sub_msb;

    logic accept;
    logic num2_zero;

    assign accept    = (state == IDLE) && start;
    assign num2_zero = (num2 == '0);
    assign busy      = (state != IDLE);

`ifdef SEQ_DIV32_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Signed mode: run the unsigned core on magnitudes; the most negative
    // value maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        mag1     = (op && num1[WIDTH-1]) ? (~num1 + 1'b1) : num1;
        mag2     = (op && num2[WIDTH-1]) ? (~num2 + 1'b1) : num2;
        neg_q_in = op && (num1[WIDTH-1] ^ num2[WIDTH-1]);
        neg_r_in = op && num1[WIDTH-1];
    end

    // Sign flags remembered for the whole operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            // A zero divisor reports the raw dividend, so no fix-up then.
            neg_q <= neg_q_in && !num2_zero;
            neg_r <= neg_r_in && !num2_zero;
        end
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign
    always_comb begin
        res_q = neg_q ? (~quot + 1'b1) : quot;
        res_r = neg_r ? (~rem + 1'b1) : rem;
    end
`else
    logic unused_op;
    assign unused_op = op;

    // Unsigned-only build: operands and results pass straight through
    always_comb begin
        mag1     = num1;
        mag2     = num2;
        neg_q_in = 1'b0;
        neg_r_in = 1'b0;
        res_q    = quot;
        res_r    = rem;
    end
`endif

    // Trial subtraction with borrow out; remainder never exceeds the divisor,
    // so the shifted value fits in WIDTH+1 bits.
    always_comb begin
        shifted        = {rem, quot[WIDTH-1]};
        sub_full       = {1'b0, shifted} - {2'b00, divisor};
        borrow         = sub_full[WIDTH+1];
        unused_sub_msb = sub_full[WIDTH];
        rem_step       = borrow ? shifted[WIDTH-1:0] : sub_full[WIDTH-1:0];
        quot_step      = {quot[WIDTH-2:0], ~borrow};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: zero divisor skips straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = num2_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot    <= '0;
            rem     <= '0;
            divisor <= '0;
            cnt     <= '0;
            dz_pend <= 1'b0;
            done    <= 1'b0;
            quotO   <= '0;
            remO    <= '0;
            divZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        divisor <= mag2;
                        cnt     <= CW'(WIDTH - 1);
                        if (num2_zero) begin
                            quot    <= '1;
                            rem     <= num1;
                            dz_pend <= 1'b1;
                        end else begin
                            quot    <= mag1;
                            rem     <= '0;
                            dz_pend <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem  <= rem_step;
                    quot <= quot_step;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    quotO   <= res_q;
                    remO    <= res_r;
                    divZero <= dz_pend;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div32.sv
// Self-checking bench for seq_div32 using a result scoreboard.
// Expected results come from a behavioural division model.
// Signed cases are exercised only when SEQ_DIV32_SIGNED_EN is defined.

module tb_seq_div32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] num1 = '0;
    logic [31:0] num2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotO;
    logic [31:0] remO;
    logic        divZero;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    exp_t last = '0;
    int   checks = 0;
    int   errors = 0;

    seq_div32 #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .num1   (num1),
        .num2   (num2),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .quotO  (quotO),
        .remO   (remO),
        .divZero(divZero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic o);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFFFFFF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
`ifdef SEQ_DIV32_SIGNED_EN
            if (o) begin
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    e.q = 32'h80000000;
                    e.r = 32'd0;
                end else begin
                    e.q = $signed(a) / $signed(b);
                    e.r = $signed(a) % $signed(b);
                end
            end
`else
            e.z = e.z & o;
`endif
        end
        return e;
    endfunction

    // Drive one start pulse and record the expected result
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic o);
        @(negedge clk);
        num1  = a;
        num2  = b;
        op    = o;
        start = 1'b1;
        sb.push_back(model(a, b, o));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count rising edges until done is seen; -1 if the budget runs out
    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) return;
        end
        cyc = -1;
    endtask

    // Count done pulses over a window
    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (quotO !== 32'd0) begin errors++; $display("FAIL reset_quot got %h want 0", quotO); end
        checks++; if (remO !== 32'd0) begin errors++; $display("FAIL reset_rem got %h want 0", remO); end
        checks++; if (divZero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %b want 0", divZero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [31:0] av [0:9];
        logic [31:0] bv [0:9];
        logic        ov [0:9];
        int          cyc;
        int          want_lat;
        exp_t        e;
        av = '{32'd100, 32'hFFFFFFFF, 32'd5, 32'h1234, 32'd9, 32'hFFFFFFF9, 32'hDEADBEEF, 32'd12345, 32'd0, 32'h80000000};
        bv = '{32'd7, 32'd1, 32'd9, 32'd0, 32'd3, 32'd2, 32'd16, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF};
        ov = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        o;
            if (i < 10) begin
                a = av[i]; b = bv[i]; o = ov[i];
            end else begin
                a = $urandom;
                b = $urandom >> $urandom_range(0, 31);
                o = 1'b0;
            end
            want_lat = (b == 32'd0) ? 1 : 33;
            issue(a, b, o);
            wait_done(40, cyc);
            e = sb.pop_front();
            last = e;
            checks++; if (cyc !== want_lat) begin errors++; $display("FAIL uns_latency a=%h b=%h got %0d want %0d", a, b, cyc, want_lat); end
            checks++; if (quotO !== e.q) begin errors++; $display("FAIL uns_quot a=%h b=%h got %h want %h", a, b, quotO, e.q); end
            checks++; if (remO !== e.r) begin errors++; $display("FAIL uns_rem a=%h b=%h got %h want %h", a, b, remO, e.r); end
            checks++; if (divZero !== e.z) begin errors++; $display("FAIL uns_divzero a=%h b=%h got %b want %b", a, b, divZero, e.z); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL uns_busy_at_done got %b want 0", busy); end
            @(posedge clk);
            #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL uns_done_pulse got %b want 0", done); end
        end
    endtask

    task automatic test_ignore_busy();
        int   cyc;
        int   pulses;
        exp_t e;
        issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        num1  = 32'd50;
        num2  = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_calc got %b want 1", busy); end
        checks++; if (quotO !== last.q) begin errors++; $display("FAIL hold_quot got %h want %h", quotO, last.q); end
        checks++; if (remO !== last.r) begin errors++; $display("FAIL hold_rem got %h want %h", remO, last.r); end
        wait_done(40, cyc);
        e = sb.pop_front();
        last = e;
        checks++; if (cyc !== 23) begin errors++; $display("FAIL busy_latency got %0d want 23", cyc); end
        checks++; if (quotO !== e.q) begin errors++; $display("FAIL busy_quot got %h want %h", quotO, e.q); end
        checks++; if (remO !== e.r) begin errors++; $display("FAIL busy_rem got %h want %h", remO, e.r); end
        count_done(45, pulses);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL busy_extra_done got %0d want 0", pulses); end
    endtask

    task automatic test_reset_abort();
        int   cyc;
        int   pulses;
        exp_t e;
        issue(32'd100, 32'd7, 1'b0);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        e = sb.pop_front();
        last = '0;
        checks++; if (quotO !== 32'd0) begin errors++; $display("FAIL abort_quot got %h want 0", quotO); end
        checks++; if (remO !== 32'd0) begin errors++; $display("FAIL abort_rem got %h want 0", remO); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (divZero !== 1'b0) begin errors++; $display("FAIL abort_divzero got %b want 0", divZero); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, pulses);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_stray_done got %0d want 0 (dropped %h)", pulses, e.q); end
        issue(32'd20, 32'd3, 1'b0);
        wait_done(40, cyc);
        e = sb.pop_front();
        last = e;
        checks++; if (cyc !== 33) begin errors++; $display("FAIL post_reset_latency got %0d want 33", cyc); end
        checks++; if (quotO !== e.q) begin errors++; $display("FAIL post_reset_quot got %h want %h", quotO, e.q); end
        checks++; if (remO !== e.r) begin errors++; $display("FAIL post_reset_rem got %h want %h", remO, e.r); end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        int   pulses;
        exp_t e;
        issue(32'd1000, 32'd10, 1'b0);
        wait_done(40, cyc);
        e = sb.pop_front();
        last = e;
        checks++; if (quotO !== e.q) begin errors++; $display("FAIL b2b_first_quot got %h want %h", quotO, e.q); end
        // Next start lands in the IDLE cycle that carries the done pulse
        issue(32'd77, 32'd8, 1'b0);
        wait_done(40, cyc);
        e = sb.pop_front();
        last = e;
        checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", cyc); end
        checks++; if (quotO !== e.q) begin errors++; $display("FAIL b2b_quot got %h want %h", quotO, e.q); end
        checks++; if (remO !== e.r) begin errors++; $display("FAIL b2b_rem got %h want %h", remO, e.r); end
        // A start raised only during the DONE cycle must be dropped
        issue(32'd200, 32'd9, 1'b0);
        repeat (32) @(posedge clk);
        @(negedge clk);
        num1  = 32'd1;
        num2  = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = sb.pop_front();
        last = e;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL donecyc_done got %b want 1", done); end
        checks++; if (quotO !== e.q) begin errors++; $display("FAIL donecyc_quot got %h want %h", quotO, e.q); end
        checks++; if (remO !== e.r) begin errors++; $display("FAIL donecyc_rem got %h want %h", remO, e.r); end
        count_done(45, pulses);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL donecyc_extra_done got %0d want 0", pulses); end
    endtask

`ifdef SEQ_DIV32_SIGNED_EN
    task automatic test_signed();
        logic [31:0] av [0:4];
        logic [31:0] bv [0:4];
        int          cyc;
        exp_t        e;
        av = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFF9C, 32'hFFFFFFF9};
        bv = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd0};
        for (int i = 0; i < 5; i++) begin
            issue(av[i], bv[i], 1'b1);
            wait_done(40, cyc);
            e = sb.pop_front();
            last = e;
            checks++; if (cyc !== ((bv[i] == 32'd0) ? 1 : 33)) begin errors++; $display("FAIL sgn_latency i=%0d got %0d", i, cyc); end
            checks++; if (quotO !== e.q) begin errors++; $display("FAIL sgn_quot a=%h b=%h got %h want %h", av[i], bv[i], quotO, e.q); end
            checks++; if (remO !== e.r) begin errors++; $display("FAIL sgn_rem a=%h b=%h got %h want %h", av[i], bv[i], remO, e.r); end
            checks++; if (divZero !== e.z) begin errors++; $display("FAIL sgn_divzero a=%h b=%h got %b want %b", av[i], bv[i], divZero, e.z); end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
`ifdef SEQ_DIV32_SIGNED_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
